// File: rtl/subpix_pkg.sv
// Shared constants and the fetch FSM state type for the sub-pixel interpolation path.
package subpix_pkg;

  localparam int unsigned PIX_W      = 8;
  localparam int unsigned WIN        = 15;
  localparam int unsigned TAP_MARGIN = 3;
  localparam int unsigned FIR_TAPS   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StCapture,
    StPresent,
    StDone
  } fetch_state_e;

endpackage

// File: rtl/coord_clamp.sv
// Signed base - TAP_MARGIN + offset, clamped to [0, LIMIT-1] for frame edge padding.
module coord_clamp
  import subpix_pkg::*;
#(
  parameter int unsigned COORD_W = 9,
  parameter int unsigned OFF_W   = 4,
  parameter int unsigned LIMIT   = 400
) (
  input  logic [COORD_W-1:0] i_base,
  input  logic [OFF_W-1:0]   i_off,
  output logic [COORD_W-1:0] o_coord
);

  localparam int unsigned SUM_W = COORD_W + 2;
  localparam logic signed [SUM_W-1:0] MARGIN_S = SUM_W'(TAP_MARGIN);
  localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(LIMIT - 1);

  logic signed [SUM_W-1:0] w_sum;

  // Two extra bits keep base + offset positive-representable and the underflow sign-visible.
  assign w_sum = $signed({2'b00, i_base}) - MARGIN_S + $signed(SUM_W'(i_off));

  always_comb begin
    o_coord = w_sum[COORD_W-1:0];
    if (w_sum[SUM_W-1]) begin
      o_coord = '0;
    end else if (w_sum > MAX_S) begin
      o_coord = MAX_S[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/ref_window_fetch.sv
// Fetches the 15x15 edge-padded luma window around an 8x8 block, one pixel read per cycle,
// and streams it out as packed rows for the sub-pixel interpolator.
module ref_window_fetch
  import subpix_pkg::*;
#(
  parameter int unsigned FRAME_W = 400,
  parameter int unsigned FRAME_H = 300,
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned COORD_W = 9
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [COORD_W-1:0]     i_blk_x,
  input  logic [COORD_W-1:0]     i_blk_y,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_mem_rd_en,
  output logic [ADDR_W-1:0]      o_mem_addr,
  input  logic [PIX_W-1:0]       i_mem_rd_data,
  output logic [WIN*PIX_W-1:0]   o_row_data,
  output logic [3:0]             o_row_idx,
  output logic                   o_row_valid,
  input  logic                   i_row_ready
);

  localparam logic [3:0] LAST = 4'(WIN - 1);

  fetch_state_e r_state, w_next_state;

  logic [COORD_W-1:0]   r_blk_x, r_blk_y;
  logic [3:0]           r_col, r_row;
  logic                 r_pend_vld;
  logic [3:0]           r_pend_col;
  logic [WIN*PIX_W-1:0] r_row_data;

  logic [COORD_W-1:0]   w_x, w_y;
  logic [ADDR_W-1:0]    w_addr;
  logic                 w_accept;
  logic                 w_handshake;

  coord_clamp #(
    .COORD_W (COORD_W),
    .OFF_W   (4),
    .LIMIT   (FRAME_W)
  ) u_clamp_x (
    .i_base  (r_blk_x),
    .i_off   (r_col),
    .o_coord (w_x)
  );

  coord_clamp #(
    .COORD_W (COORD_W),
    .OFF_W   (4),
    .LIMIT   (FRAME_H)
  ) u_clamp_y (
    .i_base  (r_blk_y),
    .i_off   (r_row),
    .o_coord (w_y)
  );

  assign w_addr      = ADDR_W'(w_y) * ADDR_W'(FRAME_W) + ADDR_W'(w_x);
  assign w_accept    = (r_state == StIdle) && i_start;
  assign w_handshake = (r_state == StPresent) && i_row_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle:    if (i_start) w_next_state = StIssue;
      StIssue:   if (r_col == LAST) w_next_state = StCapture;
      StCapture: w_next_state = StPresent;
      StPresent: if (i_row_ready) w_next_state = (r_row == LAST) ? StDone : StIssue;
      StDone:    w_next_state = StIdle;
      default:   w_next_state = StIdle;
    endcase
  end

  always_comb begin
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_mem_rd_en = 1'b0;
    o_mem_addr  = '0;
    o_row_valid = 1'b0;
    unique case (r_state)
      StIdle: ;
      StIssue: begin
        o_busy      = 1'b1;
        o_mem_rd_en = 1'b1;
        o_mem_addr  = w_addr;
      end
      StCapture: o_busy = 1'b1;
      StPresent: begin
        o_busy      = 1'b1;
        o_row_valid = 1'b1;
      end
      StDone:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_row_data = r_row_data;
  assign o_row_idx  = r_row;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_blk_x    <= '0;
      r_blk_y    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_pend_vld <= 1'b0;
      r_pend_col <= '0;
      r_row_data <= '0;
    end else begin
      // The column tag travels with the read so each pixel lands in its own lane.
      r_pend_vld <= o_mem_rd_en;
      r_pend_col <= r_col;
      for (int c = 0; c < int'(WIN); c++) begin
        if (r_pend_vld && (r_pend_col == 4'(c))) begin
          r_row_data[c*PIX_W +: PIX_W] <= i_mem_rd_data;
        end
      end
      if (w_accept) begin
        r_blk_x <= i_blk_x;
        r_blk_y <= i_blk_y;
        r_col   <= '0;
        r_row   <= '0;
      end
      if (r_state == StIssue) begin
        r_col <= (r_col == LAST) ? 4'd0 : r_col + 4'd1;
      end
      if (w_handshake && (r_row != LAST)) begin
        r_row <= r_row + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ref_window_fetch.sv
// Directed bench for ref_window_fetch: memory returns the low address byte one cycle later.
module tb_ref_window_fetch;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_start;
  logic [8:0]   i_blk_x, i_blk_y;
  logic         o_busy, o_done, o_mem_rd_en;
  logic [16:0]  o_mem_addr;
  logic [7:0]   i_mem_rd_data = 8'h00;
  logic [119:0] o_row_data;
  logic [3:0]   o_row_idx;
  logic         o_row_valid;
  logic         i_row_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic bad_addr = 1'b0;
  logic [119:0] got [15];
  int lat;

  ref_window_fetch dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_blk_x       (i_blk_x),
    .i_blk_y       (i_blk_y),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_mem_rd_en   (o_mem_rd_en),
    .o_mem_addr    (o_mem_addr),
    .i_mem_rd_data (i_mem_rd_data),
    .o_row_data    (o_row_data),
    .o_row_idx     (o_row_idx),
    .o_row_valid   (o_row_valid),
    .i_row_ready   (i_row_ready)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (o_mem_rd_en) begin
      i_mem_rd_data <= o_mem_addr[7:0];
      if (o_mem_addr >= 17'd120000) bad_addr <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int bx, input int by, input int r, input int c);
    int x, y;
    x = bx - 3 + c;
    y = by - 3 + r;
    if (x < 0) x = 0;
    if (x > 399) x = 399;
    if (y < 0) y = 0;
    if (y > 299) y = 299;
    return y * 400 + x;
  endfunction

  function automatic logic [119:0] exp_row(input int bx, input int by, input int r);
    logic [119:0] v;
    int a;
    v = '0;
    for (int c = 0; c < 15; c++) begin
      a = exp_addr(bx, by, r, c);
      v[c*8 +: 8] = 8'(a & 255);
    end
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  120'(o_busy), 120'(0));
    check({tag, "_done"},  120'(o_done), 120'(0));
    check({tag, "_rden"},  120'(o_mem_rd_en), 120'(0));
    check({tag, "_addr"},  120'(o_mem_addr), 120'(0));
    check({tag, "_data"},  o_row_data, 120'(0));
    check({tag, "_idx"},   120'(o_row_idx), 120'(0));
    check({tag, "_valid"}, 120'(o_row_valid), 120'(0));
  endtask

  // Runs one window from a negedge; optional stall at bp_row and a stray start at poke_row.
  task automatic run_window(input int bx, input int by, input int bp_row, input int poke_row,
                            output int latency);
    int k, rows, stall;
    logic snap, chk_next, poked;
    logic [119:0] sd;
    latency = -1;
    i_blk_x = 9'(bx);
    i_blk_y = 9'(by);
    i_row_ready = 1'b1;
    i_start = 1'b1;
    k = cyc;
    @(negedge i_clk);
    i_start = 1'b0;
    check("busy_after_start", 120'(o_busy), 120'(1));
    check("first_addr", 120'(o_mem_addr), 120'(exp_addr(bx, by, 0, 0)));
    rows = 0; stall = 0; snap = 1'b0; chk_next = 1'b0; poked = 1'b0; sd = '0;
    for (int g = 0; g < 600; g++) begin
      i_start = 1'b0;
      if (chk_next && !o_row_valid) begin
        check("bp_next_rden", 120'(o_mem_rd_en), 120'(1));
        check("bp_next_addr", 120'(o_mem_addr), 120'(exp_addr(bx, by, bp_row + 1, 0)));
        chk_next = 1'b0;
      end
      if (o_row_valid) begin
        if (!snap) begin
          snap = 1'b1;
          sd = o_row_data;
          check("row_data", o_row_data, exp_row(bx, by, rows));
          check("row_idx", 120'(o_row_idx), 120'(rows));
          if (rows < 15) got[rows] = o_row_data;
        end else begin
          check("bp_data_stable", o_row_data, sd);
          check("bp_idx_stable", 120'(o_row_idx), 120'(rows));
          check("bp_rden_low", 120'(o_mem_rd_en), 120'(0));
        end
        if (rows == poke_row && !poked) begin
          i_start = 1'b1;
          i_blk_x = 9'd10;
          i_blk_y = 9'd10;
          poked = 1'b1;
        end
        if (rows == bp_row && stall < 5) begin
          i_row_ready = 1'b0;
          stall++;
        end else begin
          i_row_ready = 1'b1;
          if (rows == bp_row) chk_next = 1'b1;
          rows++;
          snap = 1'b0;
        end
      end
      if (o_done) begin
        latency = cyc - k;
        check("busy_low_at_done", 120'(o_busy), 120'(0));
        check("rows_delivered", 120'(rows), 120'(15));
        break;
      end
      @(negedge i_clk);
    end
    check("window_completed", 120'(latency >= 0), 120'(1));
    i_row_ready = 1'b1;
    i_start = 1'b0;
    @(negedge i_clk);
    check("busy_low_after", 120'(o_busy), 120'(0));
  endtask

  initial begin
    i_rst = 1'b1;
    i_start = 1'b0;
    i_blk_x = '0;
    i_blk_y = '0;
    i_row_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    check_idle_outputs("reset");
    i_rst = 1'b0;
    @(negedge i_clk);

    // Interior block, ready held high.
    run_window(100, 50, -1, -1, lat);
    check("lat_100_50", 120'(lat), 120'(256));
    check("px0_100_50", 120'(got[0][7:0]), 120'(8'hD1));
    check("px14_100_50", 120'(got[0][119:112]), 120'(8'hDF));

    // Top-left corner: rows 0..3 and columns 0..3 collapse onto the frame edge.
    run_window(0, 0, -1, -1, lat);
    check("c00_row1_eq_row0", got[1], got[0]);
    check("c00_row3_eq_row0", got[3], got[0]);
    check("c00_px0_3", 120'(got[0][31:0]), 120'(0));
    check("c00_px4", 120'(got[0][39:32]), 120'(8'h01));
    check("c00_px14", 120'(got[0][119:112]), 120'(8'h0B));

    // Bottom-right corner.
    run_window(392, 292, -1, -1, lat);
    check("cbr_row11_eq_row14", got[11], got[14]);
    check("cbr_col11_eq_col14", 120'(got[14][95:88]), 120'(got[14][119:112]));
    check("cbr_px_last", 120'(got[14][119:112]), 120'(8'hBF));
    check("cbr_no_oob_addr", 120'(bad_addr), 120'(0));

    // Backpressure at row 3.
    run_window(100, 50, 3, -1, lat);
    check("bp_lat", 120'(lat), 120'(261));

    // Stray start during row 7 is ignored, then a fresh start is accepted.
    run_window(200, 100, -1, 7, lat);
    check("poke_lat", 120'(lat), 120'(256));
    run_window(5, 295, -1, -1, lat);
    check("after_done_lat", 120'(lat), 120'(256));
    check("after_done_px", 120'(got[14][7:0]), 120'(8'h32));

    // Reset in the middle of row 5 reads.
    i_blk_x = 9'd100;
    i_blk_y = 9'd50;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int g = 0; g < 200; g++) begin
      if (o_row_valid && o_row_idx == 4'd4) break;
      @(negedge i_clk);
    end
    check("rst_reach_row4", 120'(o_row_valid), 120'(1));
    repeat (4) @(negedge i_clk);
    check("rst_pre_issue", 120'(o_mem_rd_en), 120'(1));
    i_rst = 1'b1;
    @(negedge i_clk);
    check_idle_outputs("midrst");
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_no_reads", 120'(o_mem_rd_en), 120'(0));
    check("rst_data_discarded", o_row_data, 120'(0));
    run_window(100, 50, -1, -1, lat);
    check("rst_refetch_lat", 120'(lat), 120'(256));
    check("rst_refetch_px0", 120'(got[0][7:0]), 120'(8'hD1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
